ps2_note_decoder: RTL and testbench

- Sits between the PS/2 receive stage and the audio tone stage.
- Consumes the raw PS/2 Set-2 byte stream (byte + strobe).
- Decodes make, break (F0) and extended (E0) sequences, and tracks which of 13 piano keys are held.
- Drives an 8-bit note code into the audio block's note-select input and to the hex display; 0 means silence.

---
 rtl/ps2_note_decoder.sv | 214 +++++++++++++++++++++
 tb/tb_ps2_note_decoder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_note_decoder.sv
// ps2_note_decoder
// Turns the raw PS/2 Set-2 byte stream into a note code for the tone stage
// and the hex display. It decodes make, break (F0) and extended (E0) sequences.
// It tracks which of the 13 piano keys (C..C') are currently held and picks
// the key that sounds.
//
// Optional feature: define PS2_NOTE_OCTAVE_EN to add an octave register.
// Z (1A) lowers the octave and X (22) raises it, saturating at 0 and OCT_MAX.
//
// Ports:
//   CLOCK_50     system clock
//   reset        asynchronous, active-high reset
//   ps2_byte     received byte, qualified by ps2_byte_en
//   ps2_byte_en  one-cycle strobe per received byte
//   note_code    0 = silent, else NOTE_BASE + idx + 12*octave
//   note_valid   1 while any mapped key is held
//   held_keys    held bitmap, bit i = key index i
//   key_event    one-cycle pulse whenever held_keys changes
//   seq_error    one-cycle pulse on a 00/FF overrun byte
module ps2_note_decoder #(
  parameter logic [7:0] NOTE_BASE = 8'd1,
  parameter bit         LAST_WINS = 1'b1,
  parameter int         OCT_MAX   = 2
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [7:0]  ps2_byte,
  input  logic        ps2_byte_en,
  output logic [7:0]  note_code,
  output logic        note_valid,
  output logic [12:0] held_keys,
  output logic        key_event,
  output logic        seq_error
);

  localparam int OCT_W = (OCT_MAX < 1) ? 1 : $clog2(OCT_MAX + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [12:0] held_q, held_d;
  logic [3:0]  last_q, last_d;
  logic [7:0]  note_code_q, note_code_d;
  logic        note_valid_q, note_valid_d;
  logic        key_event_q, key_event_d;
  logic        seq_error_q, seq_error_d;

  logic [OCT_W-1:0] octave_q;
`ifdef PS2_NOTE_OCTAVE_EN
  logic [OCT_W-1:0] octave_d;
`endif

  // Scancode to key index; bit 4 of the result flags a mapped code.
  function automatic logic [4:0] map_key(input logic [7:0] code);
    logic [4:0] r;
    r = 5'd0;
    case (code)
      8'h1C: r = {1'b1, 4'd0};
      8'h1D: r = {1'b1, 4'd1};
      8'h1B: r = {1'b1, 4'd2};
      8'h24: r = {1'b1, 4'd3};
      8'h23: r = {1'b1, 4'd4};
      8'h2B: r = {1'b1, 4'd5};
      8'h2C: r = {1'b1, 4'd6};
      8'h34: r = {1'b1, 4'd7};
      8'h35: r = {1'b1, 4'd8};
      8'h33: r = {1'b1, 4'd9};
      8'h3C: r = {1'b1, 4'd10};
      8'h3B: r = {1'b1, 4'd11};
      8'h42: r = {1'b1, 4'd12};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  // Index of the lowest set bit; 0 when the map is empty.
  function automatic logic [3:0] lowest_idx(input logic [12:0] bits);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 12; i >= 0; i--) begin
      if (bits[i]) r = 4'(i);
    end
    return r;
  endfunction

  logic [4:0] mapped;
  logic       is_mapped;
  logic [3:0] key_idx;
  logic [3:0] sound_idx;

  assign mapped    = map_key(ps2_byte);
  assign is_mapped = mapped[4];
  assign key_idx   = mapped[3:0];

  always_comb begin
    state_d     = state_q;
    held_d      = held_q;
    last_d      = last_q;
    seq_error_d = 1'b0;
`ifdef PS2_NOTE_OCTAVE_EN
    octave_d    = octave_q;
`endif

    if (ps2_byte_en) begin
      case (state_q)
        IDLE: begin
          if (ps2_byte == 8'hF0) begin
            state_d = BRK;
          end else if (ps2_byte == 8'hE0) begin
            state_d = EXT;
          end else if (ps2_byte == 8'h00 || ps2_byte == 8'hFF) begin
            // Keyboard buffer overrun: the held state can no longer be trusted.
            held_d      = 13'd0;
            last_d      = 4'd0;
            seq_error_d = 1'b1;
          end else if (ps2_byte == 8'hAA || ps2_byte == 8'hFA ||
                       ps2_byte == 8'hFE || ps2_byte == 8'hEE) begin
            // Self-test / ack / resend / echo responses carry no key data.
            held_d = held_q;
          end else if (is_mapped) begin
            // A typematic repeat of a held key changes nothing, not even priority.
            if (!held_q[key_idx]) begin
              held_d[key_idx] = 1'b1;
              last_d          = key_idx;
            end
`ifdef PS2_NOTE_OCTAVE_EN
          end else if (ps2_byte == 8'h1A) begin
            if (octave_q != '0) octave_d = octave_q - 1'b1;
          end else if (ps2_byte == 8'h22) begin
            if (octave_q != OCT_W'(OCT_MAX)) octave_d = octave_q + 1'b1;
`endif
          end
        end

        BRK: begin
          state_d = IDLE;
          if (is_mapped && held_q[key_idx]) begin
            held_d[key_idx] = 1'b0;
            // Releasing the sounding key hands priority to the lowest held key.
            if (LAST_WINS && last_q == key_idx) last_d = lowest_idx(held_d);
          end
        end

        EXT: begin
          state_d = (ps2_byte == 8'hF0) ? EXT_BRK : IDLE;
        end

        EXT_BRK: begin
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Outputs are computed from the next-state values so that they land on
    // the same edge as held_keys.
    if (LAST_WINS && held_d[last_d]) sound_idx = last_d;
    else                             sound_idx = lowest_idx(held_d);

    note_valid_d = |held_d;
    key_event_d  = (held_d != held_q);
`ifdef PS2_NOTE_OCTAVE_EN
    note_code_d  = note_valid_d ?
                   (NOTE_BASE + 8'(sound_idx) + 8'(octave_d) * 8'd12) : 8'd0;
`else
    note_code_d  = note_valid_d ?
                   (NOTE_BASE + 8'(sound_idx) + 8'(octave_q) * 8'd12) : 8'd0;
`endif
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      held_q       <= 13'd0;
      last_q       <= 4'd0;
      note_code_q  <= 8'd0;
      note_valid_q <= 1'b0;
      key_event_q  <= 1'b0;
      seq_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      held_q       <= held_d;
      last_q       <= last_d;
      note_code_q  <= note_code_d;
      note_valid_q <= note_valid_d;
      key_event_q  <= key_event_d;
      seq_error_q  <= seq_error_d;
    end
  end

`ifdef PS2_NOTE_OCTAVE_EN
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) octave_q <= '0;
    else       octave_q <= octave_d;
  end
`else
  assign octave_q = '0;
`endif

  assign note_code  = note_code_q;
  assign note_valid = note_valid_q;
  assign held_keys  = held_q;
  assign key_event  = key_event_q;
  assign seq_error  = seq_error_q;

endmodule

// File: tb/tb_ps2_note_decoder.sv
// Directed bench for ps2_note_decoder (NOTE_BASE=1, LAST_WINS=1, OCT_MAX=2).
// Each driven byte pushes its expected post-edge outputs into a queue.
// The monitor pops one entry on the falling edge after every strobed byte.
module tb_ps2_note_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  ps2_byte = 8'h00;
  logic        ps2_byte_en = 1'b0;
  logic [7:0]  note_code;
  logic        note_valid;
  logic [12:0] held_keys;
  logic        key_event;
  logic        seq_error;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  b;
    logic [12:0] held;
    logic [7:0]  note;
    logic        kev;
    logic        se;
  } exp_t;

  exp_t exp_q[$];
  logic sampled_en = 1'b0;

  ps2_note_decoder #(.NOTE_BASE(8'd1), .LAST_WINS(1'b1), .OCT_MAX(2)) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .ps2_byte   (ps2_byte),
    .ps2_byte_en(ps2_byte_en),
    .note_code  (note_code),
    .note_valid (note_valid),
    .held_keys  (held_keys),
    .key_event  (key_event),
    .seq_error  (seq_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset) begin
    if (reset) sampled_en <= 1'b0;
    else       sampled_en <= ps2_byte_en;
  end

  task automatic check_val(input string tag, input logic [12:0] obs, input logic [12:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sampled_en) begin
      if (exp_q.size() == 0) begin
        n_assert++;
        n_fail++;
        $error("FAIL scoreboard_underflow observed=empty expected=entry");
      end else begin
        e = exp_q.pop_front();
        $display("txn byte=%02h held=%04h note=%0d valid=%0b kev=%0b se=%0b",
                 e.b, held_keys, note_code, note_valid, key_event, seq_error);
        check_val("held_keys",  held_keys,          e.held);
        check_val("note_code",  13'(note_code),     13'(e.note));
        check_val("note_valid", 13'(note_valid),    13'(|e.held));
        check_val("key_event",  13'(key_event),     13'(e.kev));
        check_val("seq_error",  13'(seq_error),     13'(e.se));
      end
    end
  end

  // Drive one byte for one cycle (strobe stays high if the next call follows).
  task automatic put(input logic [7:0] b, input logic [12:0] h, input logic [7:0] n,
                     input logic ke, input logic se);
    exp_t e;
    e.b = b; e.held = h; e.note = n; e.kev = ke; e.se = se;
    exp_q.push_back(e);
    ps2_byte    = b;
    ps2_byte_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic gap();
    ps2_byte_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state.
    check_val("rst_held",  held_keys,        13'h0000);
    check_val("rst_note",  13'(note_code),   13'd0);
    check_val("rst_valid", 13'(note_valid),  13'd0);
    check_val("rst_kev",   13'(key_event),   13'd0);
    check_val("rst_se",    13'(seq_error),   13'd0);

    // Single make, then last-wins press/release, back-to-back.
    put(8'h1C, 13'h0001, 8'd1, 1'b1, 1'b0);
    put(8'h1D, 13'h0003, 8'd2, 1'b1, 1'b0);
    put(8'hF0, 13'h0003, 8'd2, 1'b0, 1'b0);
    put(8'h1D, 13'h0001, 8'd1, 1'b1, 1'b0);
    gap();
    put(8'hF0, 13'h0001, 8'd1, 1'b0, 1'b0);
    put(8'h1C, 13'h0000, 8'd0, 1'b1, 1'b0);
    gap();

    // Typematic repeat: one event only.
    put(8'h1C, 13'h0001, 8'd1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) put(8'h1C, 13'h0001, 8'd1, 1'b0, 1'b0);
    put(8'hF0, 13'h0001, 8'd1, 1'b0, 1'b0);
    put(8'h1C, 13'h0000, 8'd0, 1'b1, 1'b0);
    gap();

    // Extended make / break and break of an unheld key do nothing.
    put(8'hE0, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'h1C, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'hE0, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'hF0, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'h1C, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'hF0, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'h42, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'hAA, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'h24, 13'h0008, 8'd4, 1'b1, 1'b0);

    // Highest key, then overrun clears everything.
    put(8'h1C, 13'h0009, 8'd1, 1'b1, 1'b0);
    put(8'h42, 13'h1009, 8'd13, 1'b1, 1'b0);
    put(8'hFF, 13'h0000, 8'd0, 1'b1, 1'b1);
    gap();

    // Reset in the middle of a break sequence discards the F0.
    put(8'hF0, 13'h0000, 8'd0, 1'b0, 1'b0);
    gap();
    #2 reset = 1'b1;
    #3 reset = 1'b0;
    @(negedge clk);
    put(8'h1B, 13'h0004, 8'd3, 1'b1, 1'b0);

    // Releasing the sounding key falls back to the lowest held key.
    put(8'h3C, 13'h0404, 8'd11, 1'b1, 1'b0);
    put(8'h1C, 13'h0405, 8'd1, 1'b1, 1'b0);
    put(8'hF0, 13'h0405, 8'd1, 1'b0, 1'b0);
    put(8'h1C, 13'h0404, 8'd3, 1'b1, 1'b0);
    put(8'h00, 13'h0000, 8'd0, 1'b1, 1'b1);
    gap();

`ifdef PS2_NOTE_OCTAVE_EN
    put(8'h22, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'h22, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'h22, 13'h0000, 8'd0, 1'b0, 1'b0);
    put(8'h1C, 13'h0001, 8'd25, 1'b1, 1'b0);
    put(8'h1A, 13'h0001, 8'd13, 1'b0, 1'b0);
    put(8'hF0, 13'h0001, 8'd13, 1'b0, 1'b0);
    put(8'h22, 13'h0001, 8'd13, 1'b0, 1'b0);
    put(8'h1A, 13'h0001, 8'd1, 1'b0, 1'b0);
    put(8'h1A, 13'h0001, 8'd1, 1'b0, 1'b0);
    gap();
`else
    // Without the octave feature, Z and X are plain unmapped codes.
    put(8'h1C, 13'h0001, 8'd1, 1'b1, 1'b0);
    put(8'h22, 13'h0001, 8'd1, 1'b0, 1'b0);
    put(8'h1A, 13'h0001, 8'd1, 1'b0, 1'b0);
    gap();
`endif

    repeat (3) @(negedge clk);
    check_val("scoreboard_drained", 13'(exp_q.size()), 13'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
